// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port 32-bit memory between the
// CPU instruction-fetch port and data port, one transaction at a time.
module mem_port_arbiter #(
    parameter int unsigned WORD_ADDRESSED = 1,
    parameter int unsigned ACCESS_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byte_en,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

    state_t          state, state_nxt;
    port_t           last_grant, winner, grant_c;
    logic            start_c;
    logic            i_req_c, d_req_c;
    logic            access_c, done_c;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_write;
    logic [BW-1:0]   cmd_be;
    logic [DW-1:0]   cmd_wdata;
    logic [CW-1:0]   cnt;

    assign i_req_c = i_read;
    assign d_req_c = d_read | d_write;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and round-robin grant decision
    always_comb begin
        state_nxt = state;
        grant_c   = PORT_D;
        start_c   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_c || d_req_c) begin
                    start_c   = 1'b1;
                    state_nxt = ACCESS;
                    if (i_req_c && d_req_c)
                        grant_c = (last_grant == PORT_D) ? PORT_I : PORT_D;
                    else
                        grant_c = i_req_c ? PORT_I : PORT_D;
                end
            end
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, access counter and per-port read data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_D;
            winner     <= PORT_D;
            cmd_addr   <= '0;
            cmd_write  <= 1'b0;
            cmd_be     <= '0;
            cmd_wdata  <= '0;
            cnt        <= '0;
            i_readdata <= '0;
            d_readdata <= '0;
        end else begin
            if (start_c) begin
                winner     <= grant_c;
                last_grant <= grant_c;
                cnt        <= CNT_INIT;
                if (grant_c == PORT_I) begin
                    cmd_addr  <= i_address;
                    cmd_write <= 1'b0;
                    cmd_be    <= '1;
                    cmd_wdata <= '0;
                end else begin
                    cmd_addr  <= d_address;
                    cmd_write <= d_write;
                    cmd_be    <= d_byte_en;
                    cmd_wdata <= d_writedata;
                end
            end
            if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else if (!cmd_write) begin
                    if (winner == PORT_I) i_readdata <= mem_readdata;
                    else                  d_readdata <= mem_readdata;
                end
            end
        end
    end

    // Memory strobes are suppressed in any reset cycle so no access can leak out
    assign access_c      = (state == ACCESS) && !reset;
    assign done_c        = (state == DONE) && !reset;
    assign mem_address   = (WORD_ADDRESSED != 0) ? {2'b00, cmd_addr[AW-1:2]} : cmd_addr;
    assign mem_read      = access_c && !cmd_write;
    assign mem_write     = access_c && cmd_write;
    assign mem_byte_en   = access_c ? (cmd_write ? cmd_be : BW'(4'hF)) : '0;
    assign mem_writedata = cmd_wdata;

    assign i_waitrequest = i_req_c && !(done_c && (winner == PORT_I));
    assign d_waitrequest = d_req_c && !(done_c && (winner == PORT_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model with random
// and directed traffic on a 1-cycle instance, directed checks on a 3-cycle one.
module tb_mem_port_arbiter;
    localparam int unsigned AC1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3, mem_clr;
    logic        i1_read, i1_wait, d1_read, d1_write, d1_wait;
    logic [31:0] i1_addr, i1_rdata, d1_addr, d1_wdata, d1_rdata;
    logic [3:0]  d1_be, m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_read, m1_write;
    logic        i3_read, i3_wait, d3_read, d3_write, d3_wait;
    logic [31:0] i3_addr, i3_rdata, d3_addr, d3_wdata, d3_rdata;
    logic [3:0]  d3_be, m3_be;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;
    logic        m3_read, m3_write;

    mem_port_arbiter #(.WORD_ADDRESSED(1), .ACCESS_CYCLES(AC1)) dut1 (
        .clk(clk), .reset(rst1),
        .i_read(i1_read), .i_address(i1_addr), .i_waitrequest(i1_wait), .i_readdata(i1_rdata),
        .d_read(d1_read), .d_write(d1_write), .d_byte_en(d1_be), .d_address(d1_addr),
        .d_writedata(d1_wdata), .d_waitrequest(d1_wait), .d_readdata(d1_rdata),
        .mem_address(m1_addr), .mem_read(m1_read), .mem_write(m1_write),
        .mem_byte_en(m1_be), .mem_writedata(m1_wdata), .mem_readdata(m1_rdata));

    mem_port_arbiter #(.WORD_ADDRESSED(1), .ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst3),
        .i_read(i3_read), .i_address(i3_addr), .i_waitrequest(i3_wait), .i_readdata(i3_rdata),
        .d_read(d3_read), .d_write(d3_write), .d_byte_en(d3_be), .d_address(d3_addr),
        .d_writedata(d3_wdata), .d_waitrequest(d3_wait), .d_readdata(d3_rdata),
        .mem_address(m3_addr), .mem_read(m3_read), .mem_write(m3_write),
        .mem_byte_en(m3_be), .mem_writedata(m3_wdata), .mem_readdata(m3_rdata));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Attached memories: combinational read, byte-merged write on posedge
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    assign m1_rdata = mem1[m1_addr[3:0]];
    assign m3_rdata = mem3[m3_addr[3:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 16; k++) begin
                mem1[k] <= '0;
                mem3[k] <= '0;
            end
            mem3[5] <= 32'h0BADF00D;
        end else begin
            if (m1_write) mem1[m1_addr[3:0]] <= merge(mem1[m1_addr[3:0]], m1_wdata, m1_be);
            if (m3_write) mem3[m3_addr[3:0]] <= merge(mem3[m3_addr[3:0]], m3_wdata, m3_be);
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, completion AC1+1 cycles after grant
    logic [31:0] rmem [16];
    int          cyc = 0, m_start = 0, m_done = 0;
    bit          mb = 1'b0, mw = 1'b0, mlast = 1'b1, m_wr = 1'b0;
    logic [31:0] m_addr, m_wd, m_rd, exp_ird, exp_drd;
    logic [3:0]  m_be;
    bit          i_ok, d_ok;
    logic [31:0] i_rd_s, d_rd_s, wr_addr;
    logic [3:0]  wr_be;

    task automatic step1();
        bit ri, rq, acc, fin;
        @(negedge clk);
        ri = i1_read;
        rq = d1_read | d1_write;
        i_ok = 1'b0;
        d_ok = 1'b0;
        if (m1_write) begin
            wr_addr = m1_addr;
            wr_be   = m1_be;
        end
        if (rst1) begin
            mb = 1'b0; mlast = 1'b1; exp_ird = '0; exp_drd = '0;
            check("rst_strobes", 32'({m1_read, m1_write, m1_be}), 32'd0);
        end else begin
            acc = mb && (cyc > m_start) && (cyc < m_done);
            fin = mb && (cyc == m_done);
            if (fin && !m_wr) begin
                if (mw) exp_drd = m_rd;
                else    exp_ird = m_rd;
            end
            check("mem_read", 32'(m1_read), 32'(acc && !m_wr));
            check("mem_write", 32'(m1_write), 32'(acc && m_wr));
            check("mem_byte_en", 32'(m1_be), acc ? 32'(m_be) : 32'd0);
            if (acc) check("mem_address", m1_addr, m_addr >> 2);
            if (acc && m_wr) check("mem_writedata", m1_wdata, m_wd);
            check("i_wait", 32'(i1_wait), 32'(ri && !(fin && !mw)));
            check("d_wait", 32'(d1_wait), 32'(rq && !(fin && mw)));
            check("i_readdata", i1_rdata, exp_ird);
            check("d_readdata", d1_rdata, exp_drd);
            if (fin) begin
                mb = 1'b0;
            end else if (!mb && (ri || rq)) begin
                mw = (ri && rq) ? !mlast : rq;
                mlast = mw; mb = 1'b1; m_start = cyc; m_done = cyc + int'(AC1) + 1;
                if (!mw) begin
                    m_wr = 1'b0; m_addr = i1_addr; m_be = 4'hF; m_wd = '0;
                end else begin
                    m_wr = d1_write; m_addr = d1_addr; m_wd = d1_wdata;
                    m_be = d1_write ? d1_be : 4'hF;
                end
                if (m_wr) rmem[m_addr[5:2]] = merge(rmem[m_addr[5:2]], m_wd, m_be);
                else      m_rd = rmem[m_addr[5:2]];
            end
            i_ok = ri && !i1_wait;
            d_ok = rq && !d1_wait;
            i_rd_s = i1_rdata;
            d_rd_s = d1_rdata;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic txn1(input bit dport, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int lat, output logic [31:0] rdata);
        bit got;
        got = 1'b0; lat = -1; rdata = '0;
        if (dport) begin
            d1_read = rd; d1_write = wr; d1_addr = a; d1_wdata = wd; d1_be = be;
        end else begin
            i1_read = 1'b1; i1_addr = a;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            step1();
            if (dport ? d_ok : i_ok) begin
                got = 1'b1; lat = k;
                rdata = dport ? d_rd_s : i_rd_s;
            end
        end
        check("txn_done", 32'(got), 32'd1);
        i1_read = 1'b0; d1_read = 1'b0; d1_write = 1'b0;
    endtask

    function automatic logic [31:0] raddr();
        return 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, ng, both_low, nmr, nwr;
        logic [31:0] rd;
        logic [3:0]  order;
        for (int k = 0; k < 16; k++) rmem[k] = '0;
        rst1 = 1'b1; rst3 = 1'b1; mem_clr = 1'b1;
        i1_read = 0; i1_addr = '0; d1_read = 0; d1_write = 0; d1_be = '0; d1_addr = '0; d1_wdata = '0;
        i3_read = 0; i3_addr = '0; d3_read = 0; d3_write = 0; d3_be = '0; d3_addr = '0; d3_wdata = '0;
        wr_addr = '0; wr_be = '0;

        // Reset then idle
        step1(); step1();
        check("rst3_strobes", 32'({m3_read, m3_write, m3_be}), 32'd0);
        rst1 = 1'b0; mem_clr = 1'b0;
        repeat (3) step1();

        // Full-word write, then instruction read of the same word
        txn1(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd);
        check("t2_write_latency", 32'(lat), 32'd2);
        check("t2_mem_address", wr_addr, 32'h4);
        txn1(0, 1, 0, 32'h10, '0, '0, lat, rd);
        check("t2_i_readdata", rd, 32'hDEADBEEF);

        // Partial byte-enable write
        txn1(1, 0, 1, 32'h10, 32'hFFFFFFFF, 4'hF, lat, rd);
        txn1(1, 0, 1, 32'h10, 32'h12345678, 4'b0011, lat, rd);
        check("t3_mem_byte_en", 32'(wr_be), 32'h3);
        txn1(1, 1, 0, 32'h10, '0, '0, lat, rd);
        check("t3_d_readdata", rd, 32'hFFFF5678);

        // Read and write together behave as a write
        txn1(1, 1, 1, 32'h20, 32'hA5A5A5A5, 4'hF, lat, rd);
        check("t6_d_readdata_kept", rd, 32'hFFFF5678);
        txn1(1, 1, 0, 32'h20, '0, '0, lat, rd);
        check("t6_write_done", rd, 32'hA5A5A5A5);

        // Contention straight out of reset: I first, then alternating
        rst1 = 1'b1;
        step1(); step1();
        rst1 = 1'b0;
        i1_read = 1; i1_addr = 32'h10; d1_read = 1; d1_addr = 32'h20;
        ng = 0; both_low = 0; order = '0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            step1();
            if (!i1_wait && !d1_wait) both_low++;
            if (i_ok) begin order = {order[2:0], 1'b0}; ng++; end
            if (d_ok) begin order = {order[2:0], 1'b1}; ng++; end
        end
        i1_read = 0; d1_read = 0;
        check("t4_grants", 32'(ng), 32'd4);
        check("t4_order", 32'(order), 32'b0101);
        check("t4_overlap", 32'(both_low), 32'd0);

        // Random traffic; each requester holds until it sees completion
        for (int n = 0; n < 600; n++) begin
            if (i1_read && i_ok) i1_read = 0;
            else if (!i1_read && $urandom_range(0, 2) == 0) begin
                i1_read = 1; i1_addr = raddr();
            end
            if ((d1_read || d1_write) && d_ok) begin
                d1_read = 0; d1_write = 0;
            end else if (!(d1_read || d1_write) && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0, 3:    begin d1_read = 1; d1_write = 0; end
                    1:       begin d1_read = 0; d1_write = 1; end
                    default: begin d1_read = 1; d1_write = 1; end
                endcase
                d1_addr = raddr(); d1_wdata = $urandom; d1_be = 4'($urandom_range(0, 15));
            end
            step1();
        end
        i1_read = 0; d1_read = 0; d1_write = 0;
        repeat (3) step1();

        // Three-cycle access: read latency and strobe width
        rst3 = 1'b0;
        @(posedge clk); #1;
        d3_read = 1; d3_addr = 32'h14;
        nmr = 0; lat = -1; rd = '0;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (m3_read) nmr++;
            if (!d3_wait) begin lat = k; rd = d3_rdata; end
            @(posedge clk); #1;
        end
        d3_read = 0;
        check("t5_read_latency", 32'(lat), 32'd4);
        check("t5_mem_read_cycles", 32'(nmr), 32'd3);
        check("t5_d_readdata", rd, 32'h0BADF00D);

        // Reset lands in the first access cycle of a write
        @(posedge clk); #1;
        d3_write = 1; d3_addr = 32'h14; d3_wdata = 32'h11111111; d3_be = 4'hF;
        @(negedge clk);
        check("t5_grant_no_write", 32'(m3_write), 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(negedge clk);
        check("t5_reset_mem_write", 32'(m3_write), 32'd0);
        check("t5_reset_d_wait", 32'(d3_wait), 32'd1);
        @(posedge clk); #1;
        rst3 = 1'b0; d3_write = 0;
        nwr = 0;
        repeat (4) begin
            @(negedge clk);
            if (m3_write) nwr++;
        end
        check("t5_no_late_write", 32'(nwr), 32'd0);
        check("t5_mem_unchanged", mem3[5], 32'h0BADF00D);
        check("t5_d_readdata_reset", d3_rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
